// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared state, halt-cause encodings and counter width for run_monitor.
package run_monitor_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HALT_NONE    = 2'd0,
        HALT_EXCEPT  = 2'd1,
        HALT_TIMEOUT = 2'd2
    } halt_t;

endpackage

// File: rtl/dump_serializer.sv
// dump_serializer: valid/ready walk over the register file, plus an XOR checksum beat
// when RUN_MONITOR_CHECKSUM_EN is defined.
module dump_serializer #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 64,
    parameter int IDX_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_REGS*REG_W-1:0] debug_reg_out,
    input  logic                      dump_ready,
    output logic                      dump_valid,
    output logic [IDX_W-1:0]          dump_idx,
    output logic [REG_W-1:0]          dump_data,
    output logic                      dump_last
);
`ifdef RUN_MONITOR_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS);
    logic [REG_W-1:0] acc;
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
`endif

    logic [IDX_W-1:0] sel;
    logic [REG_W-1:0] entry;
    logic             fire;

    // The checksum beat's index lies past the file, so keep the select in range.
    assign sel       = dump_idx < IDX_W'(NUM_REGS) ? dump_idx : '0;
    assign entry     = debug_reg_out[REG_W*sel +: REG_W];
    assign fire      = dump_valid && dump_ready;
    assign dump_last = dump_valid && dump_idx == LAST_IDX;
`ifdef RUN_MONITOR_CHECKSUM_EN
    assign dump_data = !dump_valid ? '0 : dump_idx == LAST_IDX ? acc : entry;
`else
    assign dump_data = dump_valid ? entry : '0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            dump_valid <= 1'b0;
            dump_idx   <= '0;
`ifdef RUN_MONITOR_CHECKSUM_EN
            acc        <= '0;
`endif
        end else if (start) begin
            dump_valid <= 1'b1;
            dump_idx   <= '0;
`ifdef RUN_MONITOR_CHECKSUM_EN
            acc        <= '0;
`endif
        end else if (fire) begin
            dump_valid <= !dump_last;
            dump_idx   <= dump_last ? '0 : dump_idx + IDX_W'(1);
`ifdef RUN_MONITOR_CHECKSUM_EN
            acc        <= acc ^ entry;
`endif
        end
    end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: runs the core until exception or cycle budget, then streams out its register file.
// Optional checksum beat enabled by RUN_MONITOR_CHECKSUM_EN.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int          NUM_REGS   = 32,
    parameter int          REG_W      = 64,
    parameter int unsigned MAX_CYCLES = 50
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           go,
    input  logic                           except,
    input  logic [NUM_REGS*REG_W-1:0]      debug_reg_out,
    output logic                           core_run,
    output logic [1:0]                     halt_cause,
    output logic [CNT_W-1:0]               cycle_count,
    output logic                           dump_valid,
    input  logic                           dump_ready,
    output logic [$clog2(NUM_REGS+1)-1:0]  dump_idx,
    output logic [REG_W-1:0]               dump_data,
    output logic                           dump_last,
    output logic                           done
);
    state_t state;
    logic   timeout;
    logic   halt;

    assign timeout = cycle_count + CNT_W'(1) == CNT_W'(MAX_CYCLES);
    assign halt    = state == RUN && (except || timeout);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            core_run    <= 1'b0;
            halt_cause  <= HALT_NONE;
            cycle_count <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state    <= RUN;
                    core_run <= 1'b1;
                end
                RUN: begin
                    cycle_count <= cycle_count == '1 ? cycle_count : cycle_count + CNT_W'(1);
                    if (halt) begin
                        state      <= DUMP;
                        core_run   <= 1'b0;
                        halt_cause <= except ? HALT_EXCEPT : HALT_TIMEOUT;
                    end
                end
                DUMP: if (dump_valid && dump_ready && dump_last) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    dump_serializer #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .IDX_W    ($clog2(NUM_REGS + 1))
    ) u_ser (
        .clock         (clock),
        .reset         (reset),
        .start         (halt),
        .debug_reg_out (debug_reg_out),
        .dump_ready    (dump_ready),
        .dump_valid    (dump_valid),
        .dump_idx      (dump_idx),
        .dump_data     (dump_data),
        .dump_last     (dump_last)
    );

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: table-driven run/dump scenarios with a beat scoreboard, plus a reset-mid-dump sequence.
module tb_run_monitor;
    localparam int          NUM_REGS   = 32;
    localparam int          REG_W      = 64;
    localparam int unsigned MAX_CYCLES = 10;
    localparam int          IDX_W      = $clog2(NUM_REGS + 1);

    logic                      clock = 0, reset = 0, go = 0, except = 0, dump_ready = 0;
    logic [NUM_REGS*REG_W-1:0] debug_reg_out = '0;
    logic                      core_run, dump_valid, dump_last, done;
    logic [1:0]                halt_cause;
    logic [31:0]               cycle_count;
    logic [IDX_W-1:0]          dump_idx;
    logic [REG_W-1:0]          dump_data;

    int passed = 0, total = 0;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [REG_W-1:0] data;
        logic             last;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        int         exc_cycle;
        int         pattern;
        bit         bp;
        logic [1:0] exp_cause;
        int         exp_count;
    } vec_t;
    vec_t vecs[6];

    always #5 clock = ~clock;

    run_monitor #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clock(clock), .reset(reset), .go(go), .except(except), .debug_reg_out(debug_reg_out),
        .core_run(core_run), .halt_cause(halt_cause), .cycle_count(cycle_count),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .dump_last(dump_last), .done(done)
    );

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 0; go = 0; except = 0; dump_ready = 0;
        @(negedge clock);
        check("reset ctl", {core_run, dump_valid, dump_last, done, halt_cause, dump_idx}, 0);
        check("reset cycle_count", cycle_count, 0);
        check("reset dump_data", dump_data, 0);
        reset = 1;
    endtask

    // Load the register file and push the expected beat stream.
    task automatic load(int pattern);
        logic [REG_W-1:0] e, x;
        x = '0;
        sb.delete();
        for (int i = 0; i < NUM_REGS; i++) begin
            e = pattern == 0 ? REG_W'(i * 3) : pattern == 1 ? REG_W'(64'd1 << i) : {$urandom, $urandom};
            debug_reg_out[i*REG_W +: REG_W] = e;
            x ^= e;
`ifdef RUN_MONITOR_CHECKSUM_EN
            sb.push_back('{IDX_W'(i), e, 1'b0});
`else
            sb.push_back('{IDX_W'(i), e, i == NUM_REGS - 1});
`endif
        end
`ifdef RUN_MONITOR_CHECKSUM_EN
        sb.push_back('{IDX_W'(NUM_REGS), x, 1'b1});
`endif
    endtask

    task automatic run_to_halt(int exc_cycle, output int n);
        @(negedge clock);
        go = 1;
        @(negedge clock);
        go = 0;
        n = 0;
        while (core_run && n < 1000) begin
            n++;
            except = n == exc_cycle;
            go = n == 2;
            @(negedge clock);
        end
        go = 0;
        except = 1;
    endtask

    task automatic dump(bit bp, int abort_after);
        logic [IDX_W+REG_W:0] held;
        beat_t b;
        bit stalled = 0;
        int beats = 0;
        for (int cyc = 0; !done && cyc < 500; cyc++) begin
            if (dump_valid) begin
                if (beats == abort_after) return;
                if (stalled) check("stall hold", {dump_idx, dump_data, dump_last}, held);
                dump_ready = bp ? cyc[0] : 1'b1;
                if (dump_ready) begin
                    if (sb.size() == 0) check("unexpected beat", {dump_idx, dump_data}, 0);
                    else begin
                        b = sb.pop_front();
                        check("beat", {dump_idx, dump_data, dump_last}, {b.idx, b.data, b.last});
                    end
                    beats++;
                    stalled = 0;
                end else begin
                    held = {dump_idx, dump_data, dump_last};
                    stalled = 1;
                end
            end
            @(negedge clock);
        end
        dump_ready = 0;
        check("done reached", done, 1);
        check("beats left", sb.size(), 0);
    endtask

    task automatic check_halt(int n, int exp_count, logic [1:0] exp_cause);
        check("run cycles", n, exp_count);
        check("halt_cause", halt_cause, exp_cause);
        check("cycle_count", cycle_count, exp_count);
        check("run->dump", {core_run, dump_valid, dump_idx}, {2'b01, IDX_W'(0)});
    endtask

    initial begin
        int n;
        vecs[0] = '{0, 0, 0, 2'd2, 10};
        vecs[1] = '{4, 2, 0, 2'd1, 4};
        vecs[2] = '{10, 1, 0, 2'd1, 10};
        vecs[3] = '{0, 0, 1, 2'd2, 10};
        vecs[4] = '{1, 1, 1, 2'd1, 1};
        vecs[5] = '{9, 2, 1, 2'd1, 9};

        foreach (vecs[v]) begin
            do_reset();
            load(vecs[v].pattern);
            run_to_halt(vecs[v].exc_cycle, n);
            check_halt(n, vecs[v].exp_count, vecs[v].exp_cause);
            dump(vecs[v].bp, -1);
            go = 1;
            repeat (3) @(negedge clock);
            go = 0;
            check("done frozen", {done, dump_valid, core_run, halt_cause}, {3'b100, vecs[v].exp_cause});
            check("count frozen", cycle_count, vecs[v].exp_count);
        end

        do_reset();
        load(0);
        run_to_halt(3, n);
        check_halt(n, 3, 2'd1);
        dump(0, 5);
        check("abort at beat 5", {dump_valid, dump_idx}, {1'b1, IDX_W'(5)});
        reset = 0;
        @(negedge clock);
        check("abort ctl", {core_run, dump_valid, dump_last, done, halt_cause, dump_idx}, 0);
        check("abort cycle_count", cycle_count, 0);
        check("abort dump_data", dump_data, 0);
        reset = 1;
        dump_ready = 0;
        except = 0;
        repeat (3) @(negedge clock);
        check("idle after abort", {dump_valid, core_run, done}, 0);
        load(0);
        run_to_halt(0, n);
        check_halt(n, 10, 2'd2);
        dump(1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: number of register-file entries dumped.
REQ-002 SHALL have parameter REG_W, default 64: width of one register entry.
REQ-003 SHALL have parameter MAX_CYCLES, default 50: run-cycle budget before a timeout halt; legal range 1..2^32-1.
REQ-004 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset; 0 sampled at a rising edge resets the block.
REQ-006 SHALL have port go, input, 1: start request, honoured only in IDLE.
REQ-007 SHALL have port except, input, 1: exception flag from the core.
REQ-008 SHALL have port debug_reg_out, input, NUM_REGS*REG_W: flattened register file; entry i occupies bits [i*REG_W +: REG_W].
REQ-009 SHALL have port core_run, output, 1: core clock-enable; high only in RUN.
REQ-010 SHALL have port halt_cause, output, 2: 0 none, 1 exception, 2 timeout.
REQ-011 SHALL have port cycle_count, output, 32: number of cycles spent in RUN.
REQ-012 SHALL have port dump_valid, input dump_ready, output dump_idx ($clog2(NUM_REGS+1) bits), output dump_data (REG_W bits), output dump_last (1 bit): dump stream.
REQ-013 SHALL have port done, output, 1: run and dump complete.

Function
REQ-014 SHALL implement states IDLE, RUN, DUMP and DONE.
REQ-015 SHALL move IDLE->RUN on the cycle after go=1 is sampled; go is ignored in every other state.
REQ-016 SHALL increment cycle_count by 1 on each cycle spent in RUN, saturating at 2^32-1.
REQ-017 SHALL move RUN->DUMP with halt_cause=1 when except=1 is sampled in RUN.
REQ-018 SHALL move RUN->DUMP with halt_cause=2 when the increment would make cycle_count reach MAX_CYCLES.
REQ-019 SHALL give exception priority when except and timeout coincide, setting halt_cause=1.
REQ-020 SHALL deassert core_run in the same cycle the state leaves RUN, so the register file is frozen throughout DUMP.
REQ-021 SHALL, in DUMP, drive dump_valid=1 with dump_idx starting at 0 and dump_data equal to entry dump_idx of debug_reg_out.
REQ-022 SHALL complete a beat only when dump_valid and dump_ready are both 1 at a rising edge; dump_idx then advances by 1.
REQ-023 SHALL hold dump_idx, dump_data and dump_last stable while dump_valid=1 and dump_ready=0.
REQ-024 SHALL assert dump_last on the final beat and move DUMP->DONE when that beat completes.
REQ-025 SHALL, in DONE, hold done=1, dump_valid=0 and core_run=0, and keep cycle_count and halt_cause frozen until reset.
REQ-026 SHALL ignore except outside RUN.

Reset
REQ-027 SHALL, on reset=0, enter IDLE and clear core_run, halt_cause, cycle_count, dump_valid, dump_idx, dump_data, dump_last and done to 0.
REQ-028 SHALL let reset abort any state, including DUMP mid-handshake, with no further beats emitted.

Configuration
REQ-029 SHALL use macro RUN_MONITOR_CHECKSUM_EN.
REQ-030 SHALL, when the macro is defined, append one extra beat with dump_idx=NUM_REGS and dump_data equal to the XOR of all NUM_REGS entries; dump_last is asserted on that beat only.
REQ-031 SHALL, when the macro is not defined, emit exactly NUM_REGS beats, with dump_last on index NUM_REGS-1.

Structure
REQ-032 SHALL place the state enum, the halt_cause encodings (NONE=0, EXCEPT=1, TIMEOUT=2) and the cycle-counter width constant (32) in package run_monitor_pkg.
REQ-033 SHALL implement the valid/ready index walk and the checksum accumulator in sub-module dump_serializer, instantiated once.

Verification
REQ-034 SHALL cover timeout: MAX_CYCLES=10, go pulse, except=0 -> exactly 10 cycles with core_run=1, halt_cause=2, cycle_count=10, then 32 beats.
REQ-035 SHALL cover exception: except=1 on the 4th RUN cycle -> halt_cause=1, cycle_count=4, core_run low the same cycle.
REQ-036 SHALL cover simultaneous events: except=1 on RUN cycle 10 with MAX_CYCLES=10 -> halt_cause=1.
REQ-037 SHALL cover backpressure: dump_ready toggling 0/1 with entry i=i*3 -> beats in order 0..31, each value i*3, no duplicates or drops, outputs stable while stalled.
REQ-038 SHALL cover checksum: with RUN_MONITOR_CHECKSUM_EN and entries 1,2,4,...,2^31 -> 33rd beat dump_idx=32, dump_data=0xFFFFFFFF, dump_last=1.
REQ-039 SHALL cover reset mid-dump: reset=0 at beat 5 -> next cycle in IDLE, all outputs 0, go restarts with cycle_count starting again from 0.
